// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Function : UART transmitter. Each frame is a start bit, 8 data bits sent
//            LSB first, a parity bit and a stop bit.
// Revision : 1.0
// ============================================================================
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int              CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   c_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cyc,   w_cyc_nxt;
  logic [2:0]    r_idx,   w_idx_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_parity, w_parity_nxt;
  logic          w_tx_nxt;
  logic          w_done_nxt;
  logic          w_bit_end;

  assign w_bit_end = (r_cyc == c_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cyc_nxt    = w_bit_end ? '0 : r_cyc + CW'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cyc_nxt = '0;
        if (tx_start) begin
          w_state_nxt  = S_START;
          w_shift_nxt  = data_in;
          w_parity_nxt = (^data_in) ^ PARITY_ODD;
          w_idx_nxt    = 3'd0;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx_out leaves a flop
  // already aligned with the bit it represents.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_parity_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge baud_clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cyc    <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cyc    <= w_cyc_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      tx_out   <= w_tx_nxt;
      tx_busy  <= (w_state_nxt != S_IDLE);
      tx_done  <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter paired with the receive path.
- Serialises one 8-bit byte per request into the frame the receiver checks: start bit (0), 8 data bits LSB first, parity bit, stop bit (1).
- Runs on the single baud_clk domain and times bits with an internal bit-period counter; there is no separate divided clock.
- Sits between the host-side byte source and the serial line.

Parameters:
- CLKS_PER_BIT, 16, baud_clk cycles per serial bit; legal range >= 1.
- PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = XNOR of data).

Ports:
- baud_clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  request to send data_in; sampled only while tx_busy=0.
- data_in  input  8  byte to transmit; captured on the accepting edge.
- tx_out  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx_out=1, tx_busy=0, tx_done=0.
  - State=IDLE; bit counter=0, cycle counter=0, shift register=0.
  - Applies immediately, including mid-frame; the aborted frame is never resumed.
- States: IDLE, START, DATA, PARITY, STOP (one-hot or binary, implementer's choice).
- IDLE:
  - tx_out=1, tx_busy=0.
  - On an edge with tx_start=1, latch data_in into the shift register and compute the parity bit from the latched byte.
  - Go to START; tx_busy=1 from that edge.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_out = shift register bit 0; the register shifts right at each bit boundary.
  - 8 bits, each CLKS_PER_BIT cycles; 3-bit index counts 0..7, then PARITY.
- PARITY: tx_out = stored parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - On the final edge: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Cycle counter:
  - Width max(1, $clog2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - With CLKS_PER_BIT=1, every edge is a bit boundary.
- Frame length: tx_busy high for exactly 11*CLKS_PER_BIT cycles. The first cycle of the start bit is the cycle after the accepting edge.
- Outputs are registered (tx_out driven from a flop); no combinational path from inputs to outputs.
- tx_start while tx_busy=1: ignored, not queued. data_in changes during a frame have no effect.
- Back-to-back:
  - In the tx_done cycle the FSM is already in IDLE, so tx_start=1 there is accepted.
  - The next start bit follows immediately, giving exactly one stop bit between frames.
- tx_start held high continuously: frames repeat back-to-back, each using the data_in value present on its accepting edge.

Test Plan:
- CLKS_PER_BIT=4, PARITY_ODD=0, send 0xA5 -> tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1(stop); tx_busy high 44 cycles; tx_done pulses once on cycle 45; tx_out=1 afterwards.
- PARITY_ODD=1, send 0x01 -> parity bit 0; repeat with PARITY_ODD=0 -> parity bit 1; send 0x00 with PARITY_ODD=1 -> parity bit 1.
- Send 0x3C, then pulse tx_start with data_in=0xFF at cycle 10 of the frame -> ignored; only the 0x3C frame appears; tx_done pulses once.
- tx_start=1 in the tx_done cycle with data_in=0xFF after a 0x00 frame -> start bit begins on the next cycle; the line shows exactly 4 high stop cycles between the two frames.
- Assert reset low during DATA bit 3 of 0x5A -> tx_out=1, tx_busy=0 without waiting for a clock edge; after release, the line stays idle until a new tx_start.
- CLKS_PER_BIT=1, send 0x81 -> 11-cycle frame 0,1,0,0,0,0,0,0,1,0,1; tx_done on cycle 12.
